tx_audio_mem: RTL and testbench

TX_AUDIO_MEM -- requirements
Module: tx_audio_mem

---
 rtl/tx_audio_mem_if.sv | 33 +++
 rtl/tx_audio_mem.sv | 170 +++++++++++++++++
 tb/tb_tx_audio_mem.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_audio_mem_if.sv
// Host-write and audio-frame bus of tx_audio_mem.
// The design side uses the slave modport; the host/bench side uses master.
interface tx_audio_mem_if #(
   parameter int unsigned V_TX_CHANS    = 4,
   parameter int unsigned BUF_ADDR_BITS = 11
);
   logic                        flush;
   logic [7:0]                  nsamps;
   logic                        wr_en;
   logic [15:0]                 wr_data;
   logic                        full;
   logic [BUF_ADDR_BITS:0]      level;
   logic                        wr_drop;
   logic                        tx_req;
   logic                        tx_valid;
   logic [V_TX_CHANS*32-1:0]    tx_iq_dout;
   logic                        srq;
   logic [15:0]                 blk_ctr;
   logic [7:0]                  underrun_cnt;
   logic [7:0]                  overrun_cnt;

   modport master (
      output flush, nsamps, wr_en, wr_data, tx_req,
      input  full, level, wr_drop, tx_valid, tx_iq_dout, srq, blk_ctr,
             underrun_cnt, overrun_cnt
   );

   modport slave (
      input  flush, nsamps, wr_en, wr_data, tx_req,
      output full, level, wr_drop, tx_valid, tx_iq_dout, srq, blk_ctr,
             underrun_cnt, overrun_cnt
   );
endinterface

// File: rtl/tx_audio_mem.sv
// TX audio sample buffer: host fills a circular word buffer, each tx_req pulls
// one frame of {Q,I} words for all channels, or zeros on underrun.
module tx_audio_mem #(
   parameter int unsigned V_TX_CHANS    = 4,
   parameter int unsigned BUF_ADDR_BITS = 11
) (
   input logic           adc_clk,
   input logic           reset_n,
   tx_audio_mem_if.slave bus
);
   localparam int unsigned NW    = 2 * V_TX_CHANS;
   localparam int unsigned DEPTH = 1 << BUF_ADDR_BITS;
   localparam int unsigned LW    = BUF_ADDR_BITS + 1;
   localparam int unsigned CW    = $clog2(NW + 1);
   localparam int unsigned IW    = $clog2(NW);
   localparam int unsigned DW    = V_TX_CHANS * 32;
   localparam int unsigned AW    = BUF_ADDR_BITS;

   typedef enum logic [1:0] {IDLE, FETCH, LAST, UNDER} state_t;

   state_t               state_q, state_d;
   logic [AW-1:0]        waddr_q, waddr_d;
   logic [AW-1:0]        raddr_q, raddr_d;
   logic [LW-1:0]        level_q, level_d;
   logic                 full_q, full_d;
   logic                 wr_drop_q, wr_drop_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NW-1:0][15:0]  shadow_q, shadow_d;
   logic [DW-1:0]        dout_q, dout_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 srq_q, srq_d;
   logic [15:0]          blk_q, blk_d;
   logic [8:0]           frame_q, frame_d;
   logic [7:0]           under_q, under_d;
   logic [7:0]           over_q, over_d;
   logic                 rd_en_c;
   logic                 wr_acc_c;
   logic [8:0]           target_c;
   logic [15:0]          mem_q [DEPTH];
   logic [15:0]          rdata_q;

   // Buffer RAM: synchronous write, registered read (one-cycle latency).
   always_ff @(posedge adc_clk) begin
      if (wr_acc_c) mem_q[waddr_q] <= bus.wr_data;
      rdata_q <= mem_q[raddr_q];
   end

   always_ff @(posedge adc_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         waddr_q    <= '0;
         raddr_q    <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         wr_drop_q  <= 1'b0;
         cnt_q      <= '0;
         shadow_q   <= '0;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
         srq_q      <= 1'b0;
         blk_q      <= '0;
         frame_q    <= '0;
         under_q    <= '0;
         over_q     <= '0;
      end else begin
         state_q    <= state_d;
         waddr_q    <= waddr_d;
         raddr_q    <= raddr_d;
         level_q    <= level_d;
         full_q     <= full_d;
         wr_drop_q  <= wr_drop_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         dout_q     <= dout_d;
         tx_valid_q <= tx_valid_d;
         srq_q      <= srq_d;
         blk_q      <= blk_d;
         frame_q    <= frame_d;
         under_q    <= under_d;
         over_q     <= over_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      dout_d     = dout_q;
      tx_valid_d = 1'b0;
      srq_d      = 1'b0;
      blk_d      = blk_q;
      frame_d    = frame_q;
      under_d    = under_q;
      over_d     = over_q;
      wr_drop_d  = wr_drop_q;
      rd_en_c    = 1'b0;
      target_c   = (bus.nsamps == 8'd0) ? 9'd256 : {1'b0, bus.nsamps};

      wr_acc_c = bus.wr_en && !full_q && !bus.flush;
      if (bus.wr_en && full_q && !bus.flush) wr_drop_d = 1'b1;
      if (bus.tx_req && (state_q != IDLE) && !bus.flush && (over_q != 8'hFF))
         over_d = over_q + 8'd1;

      case (state_q)
         IDLE: begin
            if (bus.tx_req) begin
               cnt_d   = '0;
               state_d = (level_q >= LW'(NW)) ? FETCH : UNDER;
            end
         end
         FETCH: begin
            // Word read last cycle lands in its shadow slot now.
            rd_en_c = 1'b1;
            if (cnt_q != '0) shadow_d[IW'(cnt_q - CW'(1))] = rdata_q;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NW - 1)) state_d = LAST;
         end
         LAST: begin
            shadow_d[NW-1] = rdata_q;
            dout_d         = shadow_d;
            tx_valid_d     = 1'b1;
            state_d        = IDLE;
            if (frame_q + 9'd1 == target_c) begin
               frame_d = '0;
               blk_d   = blk_q + 16'd1;
               srq_d   = 1'b1;
            end else begin
               frame_d = frame_q + 9'd1;
            end
         end
         UNDER: begin
            dout_d     = '0;
            tx_valid_d = 1'b1;
            state_d    = IDLE;
            if (under_q != 8'hFF) under_d = under_q + 8'd1;
         end
      endcase

      waddr_d = waddr_q + AW'(wr_acc_c);
      raddr_d = raddr_q + AW'(rd_en_c);
      level_d = level_q + LW'(wr_acc_c) - LW'(rd_en_c);

      // Flush wins over everything in flight; output data and counters survive.
      if (bus.flush) begin
         waddr_d    = '0;
         raddr_d    = '0;
         level_d    = '0;
         frame_d    = '0;
         wr_drop_d  = 1'b0;
         state_d    = IDLE;
         tx_valid_d = 1'b0;
         srq_d      = 1'b0;
         blk_d      = blk_q;
         dout_d     = dout_q;
         under_d    = under_q;
      end

      full_d = (level_d == LW'(DEPTH));
   end

   assign bus.full         = full_q;
   assign bus.level        = level_q;
   assign bus.wr_drop      = wr_drop_q;
   assign bus.tx_valid     = tx_valid_q;
   assign bus.tx_iq_dout   = dout_q;
   assign bus.srq          = srq_q;
   assign bus.blk_ctr      = blk_q;
   assign bus.underrun_cnt = under_q;
   assign bus.overrun_cnt  = over_q;
endmodule

// File: tb/tb_tx_audio_mem.sv
// Bench for tx_audio_mem (4 channels, 16-word buffer): table of fill/request
// vectors plus hand sequences; frames checked through a scoreboard queue.
module tb_tx_audio_mem;
   localparam int unsigned NCH = 4;
   localparam int unsigned AB  = 4;

   typedef struct {
      logic [127:0] dout;
      int           cyc;
      logic         srq;
   } exp_t;

   typedef struct {
      int          nw;
      logic [15:0] base;
      int          lvl_pre;
      logic        full_pre;
      int          lvl_post;
      int          under_tot;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   exp_t        sb[$];
   logic [15:0] words_m[$];
   int          frame_m = 0;
   int          blk_m = 0;
   int          under_m = 0;
   int          over_m = 0;
   int          target_m = 256;

   tx_audio_mem_if #(.V_TX_CHANS(NCH), .BUF_ADDR_BITS(AB)) bus ();

   tx_audio_mem #(.V_TX_CHANS(NCH), .BUF_ADDR_BITS(AB)) dut (
      .adc_clk (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #400000;
      $display("FAIL watchdog act=running req=finished");
      $fatal(1, "watchdog");
   end

   function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h req=%0h", nm, act, exp);
      end
   endfunction

   // Output monitor: every tx_valid must match the oldest expected frame.
   always @(negedge clk) begin
      if (rst_n && bus.tx_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 128'd1, 128'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("dout", bus.tx_iq_dout, e.dout);
            chk("latency", 128'(cyc), 128'(e.cyc));
            chk("srq", 128'(bus.srq), 128'(e.srq));
         end
      end else if (rst_n && bus.srq) begin
         chk("srq_no_valid", 128'(bus.srq), 128'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_words(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_data = base + 16'(i);
         if (words_m.size() < 16) words_m.push_back(base + 16'(i));
         step();
      end
      bus.wr_en = 1'b0;
   endtask

   task automatic do_flush(input logic with_wr);
      bus.flush   = 1'b1;
      bus.wr_en   = with_wr;
      bus.wr_data = 16'hDEAD;
      step();
      bus.flush = 1'b0;
      bus.wr_en = 1'b0;
      words_m.delete();
      frame_m = 0;
   endtask

   // Request from IDLE: model decides fetch or underrun.
   task automatic do_req();
      exp_t e;
      e.dout = '0;
      e.srq  = 1'b0;
      if (words_m.size() >= 8) begin
         for (int j = 0; j < 8; j++) e.dout[16*j +: 16] = words_m.pop_front();
         e.cyc = cyc + 10;
         frame_m++;
         if (frame_m == target_m) begin
            frame_m = 0;
            blk_m++;
            e.srq = 1'b1;
         end
      end else begin
         e.cyc = cyc + 2;
         under_m++;
      end
      sb.push_back(e);
      bus.tx_req = 1'b1;
      step();
      bus.tx_req = 1'b0;
   endtask

   task automatic busy_req();
      over_m++;
      bus.tx_req = 1'b1;
      step();
      bus.tx_req = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) step();
      chk("drain", 128'(sb.size()), 128'd0);
   endtask

   task automatic chk_all_zero(string nm);
      chk({nm, "_full"},  128'(bus.full), 128'd0);
      chk({nm, "_level"}, 128'(bus.level), 128'd0);
      chk({nm, "_drop"},  128'(bus.wr_drop), 128'd0);
      chk({nm, "_valid"}, 128'(bus.tx_valid), 128'd0);
      chk({nm, "_dout"},  bus.tx_iq_dout, 128'd0);
      chk({nm, "_srq"},   128'(bus.srq), 128'd0);
      chk({nm, "_blk"},   128'(bus.blk_ctr), 128'd0);
      chk({nm, "_under"}, 128'(bus.underrun_cnt), 128'd0);
      chk({nm, "_over"},  128'(bus.overrun_cnt), 128'd0);
   endtask

   initial begin
      vec_t vt[5];
      vt[0] = '{nw: 8,  base: 16'h0001, lvl_pre: 8,  full_pre: 1'b0, lvl_post: 0, under_tot: 0};
      vt[1] = '{nw: 0,  base: 16'h0000, lvl_pre: 0,  full_pre: 1'b0, lvl_post: 0, under_tot: 1};
      vt[2] = '{nw: 5,  base: 16'h0050, lvl_pre: 5,  full_pre: 1'b0, lvl_post: 5, under_tot: 2};
      vt[3] = '{nw: 12, base: 16'h0100, lvl_pre: 12, full_pre: 1'b0, lvl_post: 4, under_tot: 2};
      vt[4] = '{nw: 16, base: 16'hA000, lvl_pre: 16, full_pre: 1'b1, lvl_post: 8, under_tot: 2};

      bus.flush = 1'b0; bus.nsamps = 8'd0; bus.wr_en = 1'b0;
      bus.wr_data = '0; bus.tx_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 5; i++) begin
         do_flush(1'b0);
         write_words(vt[i].nw, vt[i].base);
         chk("vec_level_pre", 128'(bus.level), 128'(vt[i].lvl_pre));
         chk("vec_full_pre", 128'(bus.full), 128'(vt[i].full_pre));
         do_req();
         drain();
         chk("vec_level_post", 128'(bus.level), 128'(vt[i].lvl_post));
         chk("vec_under", 128'(bus.underrun_cnt), 128'(vt[i].under_tot));
         if (i == 0) begin
            chk("ch0", 128'(bus.tx_iq_dout[31:0]), 128'h0002_0001);
            chk("ch3", 128'(bus.tx_iq_dout[127:96]), 128'h0008_0007);
         end
      end

      // Block boundary with nsamps=2.
      bus.nsamps = 8'd2; target_m = 2;
      do_flush(1'b0);
      write_words(16, 16'h2000);
      do_req();
      repeat (19) step();
      do_req();
      drain();
      chk("blk_ctr", 128'(bus.blk_ctr), 128'(blk_m));
      chk("blk_ctr_one", 128'(bus.blk_ctr), 128'd1);
      bus.nsamps = 8'd0; target_m = 256;

      // Fill past capacity, then read across the pointer wrap.
      do_flush(1'b0);
      write_words(17, 16'h3000);
      chk("ovf_full", 128'(bus.full), 128'd1);
      chk("ovf_level", 128'(bus.level), 128'd16);
      chk("ovf_drop", 128'(bus.wr_drop), 128'd1);
      do_req(); drain();
      write_words(8, 16'h4000);
      chk("wrap_full", 128'(bus.full), 128'd1);
      do_req(); drain();
      do_req(); drain();
      chk("wrap_level", 128'(bus.level), 128'd0);
      chk("drop_sticky", 128'(bus.wr_drop), 128'd1);
      do_flush(1'b0);
      chk("drop_cleared", 128'(bus.wr_drop), 128'd0);

      // Request while busy: counted, fetch latency untouched.
      write_words(8, 16'h5000);
      do_req();
      repeat (2) step();
      busy_req();
      drain();
      chk("overrun", 128'(bus.overrun_cnt), 128'(over_m));

      // Flush (with a concurrent write) aborts an in-flight fetch.
      write_words(8, 16'h6000);
      do_req();
      repeat (2) step();
      void'(sb.pop_back());
      do_flush(1'b1);
      repeat (14) step();
      chk("flush_level", 128'(bus.level), 128'd0);
      chk("flush_full", 128'(bus.full), 128'd0);
      do_req();
      drain();
      chk("flush_idle_under", 128'(bus.underrun_cnt), 128'(under_m));

      // Asynchronous reset in the middle of a fetch.
      write_words(8, 16'h7000);
      do_req();
      repeat (2) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      sb.delete(); words_m.delete();
      frame_m = 0; blk_m = 0; under_m = 0; over_m = 0;
      step();
      rst_n = 1'b1;
      repeat (12) step();
      chk("post_rst_level", 128'(bus.level), 128'd0);
      do_req();
      drain();
      chk("post_rst_under", 128'(bus.underrun_cnt), 128'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
